// File: rtl/simon_serial_pkg.sv
// Shared constants for the bit-serial Simon 128/128 core and its host-side driver:
// mode encodings, driver state codes and default geometry.
package simon_serial_pkg;

  localparam int DEF_BLOCK_W    = 128;
  localparam int DEF_KEY_W      = 128;
  localparam int DEF_RUN_CYCLES = 4352;

  localparam logic [1:0] MODE_IDLE     = 2'd0;
  localparam logic [1:0] MODE_LOAD_PT  = 2'd1;
  localparam logic [1:0] MODE_LOAD_KEY = 2'd2;
  localparam logic [1:0] MODE_RUN      = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_PT  = 3'd1;
  localparam state_t ST_LOAD_KEY = 3'd2;
  localparam state_t ST_RUN      = 3'd3;
  localparam state_t ST_UNLOAD   = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  // The core keeps run mode while its result is streamed out, so UNLOAD reuses MODE_RUN.
  function automatic logic [1:0] mode_of(input state_t s);
    case (s)
      ST_LOAD_PT:  mode_of = MODE_LOAD_PT;
      ST_LOAD_KEY: mode_of = MODE_LOAD_KEY;
      ST_RUN:      mode_of = MODE_RUN;
      ST_UNLOAD:   mode_of = MODE_RUN;
      default:     mode_of = MODE_IDLE;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/simon_serial_shifter.sv
// Datapath for the serial host driver: a {key, plaintext} parallel-in/serial-out register
// feeding the core, and a serial-in capture register collecting the ciphertext.
module simon_serial_shifter #(
  parameter int BLOCK_W = 128,
  parameter int KEY_W   = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               capture_en,
  input  logic [BLOCK_W-1:0] pt_in,
  input  logic [KEY_W-1:0]   key_in,
  input  logic               ser_in,
  output logic               ser_bit,
  output logic [BLOCK_W-1:0] capture_next
);

  logic [KEY_W+BLOCK_W-1:0] piso;
  logic [BLOCK_W-1:0]       capture;

  // Plaintext sits in the low half so it leaves first; zeros fill behind, keeping ser_data low afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        piso <= '0;
    else if (clear)    piso <= '0;
    else if (load)     piso <= {key_in, pt_in};
    else if (shift_en) piso <= piso >> 1;
  end

  assign ser_bit      = piso[0];
  assign capture_next = {ser_in, capture[BLOCK_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          capture <= '0;
    else if (capture_en) capture <= capture_next;
  end

endmodule

// File: rtl/simon_serial_host_driver.sv
// Host-side initiator for the bit-serial Simon 128/128 core: serializes plaintext and key,
// runs the core for a full encryption and deserializes the ciphertext into a parallel word.
module simon_serial_host_driver
  import simon_serial_pkg::*;
#(
  parameter int BLOCK_W    = DEF_BLOCK_W,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               ser_data,
  output logic [1:0]         ser_mode,
  input  logic               ser_cipher
);

  localparam int CNT_MAX = max3(BLOCK_W, KEY_W, RUN_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, reload_val;
  logic               entering;
  logic               busy_state;
  logic [BLOCK_W-1:0] capture_next;

  assign busy_state = (state != ST_IDLE);
  assign entering   = (state_nx != state);

  // Abort overrides any phase transition; start is only honoured from IDLE without abort.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start && !abort) state_nx = ST_LOAD_PT;
      ST_LOAD_PT:  if (cnt == '0) state_nx = ST_LOAD_KEY;
      ST_LOAD_KEY: if (cnt == '0) state_nx = ST_RUN;
      ST_RUN:      if (cnt == '0) state_nx = ST_UNLOAD;
      ST_UNLOAD:   if (cnt == '0) state_nx = ST_DONE;
      ST_DONE:     state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
    if (abort && busy_state) state_nx = ST_IDLE;
  end

  always_comb begin
    reload_val = '0;
    case (state_nx)
      ST_LOAD_PT:  reload_val = CNT_W'(BLOCK_W - 1);
      ST_LOAD_KEY: reload_val = CNT_W'(KEY_W - 1);
      ST_RUN:      reload_val = CNT_W'(RUN_CYCLES - 1);
      ST_UNLOAD:   reload_val = CNT_W'(BLOCK_W - 1);
      default:     reload_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (entering)        cnt <= reload_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
    end
  end

  // Status outputs are registered from the next state so they line up with the phase they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      ser_mode   <= MODE_IDLE;
      ciphertext <= '0;
    end else begin
      busy     <= (state_nx != ST_IDLE);
      done     <= (state_nx == ST_DONE);
      ser_mode <= mode_of(state_nx);
      if (state == ST_UNLOAD && state_nx == ST_DONE) ciphertext <= capture_next;
    end
  end

  simon_serial_shifter #(
    .BLOCK_W (BLOCK_W),
    .KEY_W   (KEY_W)
  ) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (state == ST_IDLE && state_nx == ST_LOAD_PT),
    .shift_en     (state == ST_LOAD_PT || state == ST_LOAD_KEY),
    .clear        (abort && busy_state),
    .capture_en   (state == ST_UNLOAD),
    .pt_in        (plaintext),
    .key_in       (key),
    .ser_in       (ser_cipher),
    .ser_bit      (ser_data),
    .capture_next (capture_next)
  );

endmodule

// File: tb/tb_simon_serial_host_driver.sv
// Scoreboard bench for simon_serial_host_driver with a behavioural stand-in for the serial core
// that returns a chosen 128-bit response LSB-first during the unload phase.
module tb_simon_serial_host_driver;
  import simon_serial_pkg::*;

  localparam int BW  = 128;
  localparam int KW  = 128;
  localparam int RC  = 4352;
  localparam int LAT = BW + KW + RC + BW;

  localparam logic [127:0] G_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] G_PT  = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] G_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;
  localparam logic [127:0] PAT_A5  = {16{8'hA5}};
  localparam logic [127:0] PAT_SEQ = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] PAT_C   = 128'hdeadbeef00000001_8000000012345678;
  localparam logic [127:0] PAT_D   = 128'h5555aaaa3333cccc_0f0f0f0ff0f0f0f1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [BW-1:0]  plaintext = '0;
  logic [KW-1:0]  key = '0;
  logic           busy, done, ser_data;
  logic [BW-1:0]  ciphertext;
  logic [1:0]     ser_mode;
  logic           ser_cipher = 1'b0;

  simon_serial_host_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .plaintext  (plaintext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext),
    .ser_data   (ser_data),
    .ser_mode   (ser_mode),
    .ser_cipher (ser_cipher)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            tests_run = 0;
  int            tests_failed = 0;
  int            done_cnt = 0;
  int            done_base = 0;
  int            m3 = 0;
  logic [127:0]  stub_resp = '0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Core stand-in: after RC run cycles in mode 3, present response bit k in unload cycle k.
  always @(negedge clk) begin
    if (ser_mode == MODE_RUN) begin
      if (m3 >= RC && m3 < RC + BW) ser_cipher = stub_resp[m3 - RC];
      else                          ser_cipher = 1'b0;
      m3++;
    end else begin
      m3 = 0;
      ser_cipher = 1'b0;
    end
  end

  // Monitor: every done pulse must match the oldest outstanding job.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 128'(done), 128'(0));
      end else begin
        e = sb.pop_front();
        checkOutput("done_ciphertext", ciphertext, e.ct);
        checkOutput("done_latency", 128'(cyc), 128'(e.due));
        checkOutput("busy_in_done", 128'(busy), 128'(1));
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] resp, input bit expect_done);
    exp_t e;
    @(negedge clk);
    #1;
    plaintext = pt;
    key       = k;
    stub_resp = resp;
    start     = 1'b1;
    done_base = done_cnt;
    if (expect_done) begin
      e.ct  = resp;
      e.due = cyc + 1 + LAT;
      sb.push_back(e);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int waited;
    waited = 0;
    while (done_cnt <= done_base && waited < budget) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (done_cnt <= done_base) checkOutput("done_timeout", 128'(0), 128'(1));
  endtask

  // Walks cycle 0 .. LAT of a job, comparing mode and serial data against the expected schedule.
  task automatic serialCheck(input int one_a, input int one_b);
    int         bad_mode;
    int         bad_data;
    logic [1:0] em;
    logic       ed;
    bad_mode = 0;
    bad_data = 0;
    for (int i = 0; i <= LAT; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (i < BW)           em = MODE_LOAD_PT;
      else if (i < BW + KW) em = MODE_LOAD_KEY;
      else if (i < LAT)     em = MODE_RUN;
      else                  em = MODE_IDLE;
      ed = (i == one_a || i == one_b);
      if (ser_mode !== em) bad_mode++;
      if (ser_data !== ed) bad_data++;
    end
    checkOutput("ser_mode_sequence_errors", 128'(bad_mode), 128'(0));
    checkOutput("ser_data_sequence_errors", 128'(bad_data), 128'(0));
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #12;
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));
    checkOutput("reset_mode", 128'(ser_mode), 128'(0));
    checkOutput("reset_data", 128'(ser_data), 128'(0));
    checkOutput("reset_ciphertext", ciphertext, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // start together with abort in IDLE is ignored
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_idle_busy", 128'(busy), 128'(0));
    checkOutput("start_abort_idle_mode", 128'(ser_mode), 128'(0));

    // golden vector with the core stand-in returning the known ciphertext
    applyStimulus(G_PT, G_KEY, G_CT, 1'b1);
    checkOutput("busy_after_start", 128'(busy), 128'(1));
    checkOutput("mode_after_start", 128'(ser_mode), 128'(MODE_LOAD_PT));
    checkOutput("first_ser_bit", 128'(ser_data), 128'(0));
    waitDone(LAT + 20);

    // serializer schedule: pt bit 0 in LOAD_PT cycle 0, key bit 127 in LOAD_KEY cycle 127
    applyStimulus(128'h1, {1'b1, 127'b0}, PAT_A5, 1'b1);
    serialCheck(0, BW + KW - 1);
    waitDone(4);

    // start pulsed mid-run is ignored; asymmetric pattern pins down bit order
    applyStimulus(G_PT, G_KEY, PAT_SEQ, 1'b1);
    repeat (600) @(negedge clk);
    #1;
    plaintext = PAT_C;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_during_run", 128'(busy), 128'(1));
    checkOutput("mode_during_run", 128'(ser_mode), 128'(MODE_RUN));
    waitDone(LAT + 20);
    repeat (8) @(negedge clk);
    #1;
    checkOutput("single_done_for_ignored_start", 128'(sb.size()), 128'(0));

    // async reset at RUN cycle 1000 discards the job
    applyStimulus(G_PT, G_KEY, PAT_C, 1'b1);
    repeat (BW + KW + 1000) @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("midrun_reset_mode", 128'(ser_mode), 128'(0));
    checkOutput("midrun_reset_busy", 128'(busy), 128'(0));
    checkOutput("midrun_reset_ciphertext", ciphertext, 128'(0));
    checkOutput("midrun_reset_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(PAT_D, PAT_C, PAT_D, 1'b1);
    waitDone(LAT + 20);

    // abort in UNLOAD cycle 50: no done, prior ciphertext held
    applyStimulus(G_PT, G_KEY, PAT_A5, 1'b0);
    repeat (BW + KW + RC + 50) @(negedge clk);
    #1;
    checkOutput("mode_in_unload", 128'(ser_mode), 128'(MODE_RUN));
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_mode", 128'(ser_mode), 128'(0));
    checkOutput("abort_done", 128'(done), 128'(0));
    checkOutput("abort_ciphertext_held", ciphertext, PAT_D);
    repeat (20) @(negedge clk);

    // back-to-back jobs, each started on the first edge after done drops
    applyStimulus(G_PT, G_KEY, PAT_SEQ, 1'b1);
    waitDone(LAT + 20);
    applyStimulus(PAT_C, PAT_D, G_CT, 1'b1);
    waitDone(LAT + 20);

    repeat (4) @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
